// File: rtl/leb128_reader.sv
// rtl/leb128_reader.sv - LEB128 immediate-operand fetch and decode stage
//
// Purpose:
//    Decodes one WebAssembly LEB128 integer (signed or unsigned, 32- or
//    64-bit target) starting at a byte address in the wide instruction ROM.
//    The ROM is read one 2**MEM_EXTRA-byte window at a time. One encoded
//    byte is consumed per cycle. The decoded value, the byte length and an
//    error flag are returned to the core so that it can advance the PC.
//
// Ports:
//    clk        in   clock, rising edge
//    reset      in   asynchronous active-low reset
//    start      in   decode request, sampled only while busy=0
//    pc         in   byte address of the first LEB128 byte
//    is_signed  in   1 = sLEB128, 0 = uLEB128
//    width64    in   1 = 64-bit target (max 10 bytes), 0 = 32-bit (max 5)
//    busy       out  high while a decode is in flight
//    done       out  one-cycle completion pulse
//    value      out  decoded value (upper half zero for 32-bit targets)
//    length     out  number of bytes consumed
//    error      out  overlong encoding or ROM bounds error
//    mem_addr   out  ROM window base address
//    mem_extra  out  extra bytes requested from the ROM (always all-ones)
//    mem_data   in   ROM window data, byte 0 at the lowest address
//    mem_error  in   ROM bounds error, qualifies mem_data

module leb128_reader #(
   parameter int MEM_DEPTH = 5,
   parameter int MEM_EXTRA = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [MEM_DEPTH:0]            pc,
   input  logic                          is_signed,
   input  logic                          width64,
   output logic                          busy,
   output logic                          done,
   output logic [63:0]                   value,
   output logic [3:0]                    length,
   output logic                          error,
   output logic [MEM_DEPTH:0]            mem_addr,
   output logic [MEM_EXTRA-1:0]          mem_extra,
   input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
   input  logic                          mem_error
);

   localparam int AW       = MEM_DEPTH + 1;
   localparam int WIN_BITS = (2**MEM_EXTRA) * 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_DECODE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Operation context latched at start
   logic [AW-1:0]        pc_q;
   logic                 signed_q;
   logic                 w64_q;

   // Decode datapath
   logic [63:0]          acc;
   logic [3:0]           idx;
   logic [6:0]           shift;
   logic [WIN_BITS-1:0]  buffer;
   logic [MEM_EXTRA-1:0] boff;

   // One-byte decode step, evaluated every cycle, used only in S_DECODE
   logic [7:0]           cur_byte;
   logic [63:0]          acc_step;
   logic [6:0]           shift_step;
   logic [3:0]           idx_step;
   logic [3:0]           max_len;
   logic [6:0]           width_bits;
   logic                 byte_last;
   logic                 byte_overlong;
   logic                 win_end;
   logic [63:0]          value_final;
   logic [63:0]          value_overlong;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Decode step
   // ------------------------------------------------------------------
   always_comb begin
      cur_byte      = buffer[{boff, 3'b000} +: 8];
      // Payload bits shifted past bit 63 fall off the left end. For 32-bit
      // targets the upper half is cleared when the result is formed.
      acc_step      = acc | ({57'd0, cur_byte[6:0]} << shift);
      shift_step    = shift + 7'd7;
      idx_step      = idx + 4'd1;
      max_len       = w64_q ? 4'd10 : 4'd5;
      width_bits    = w64_q ? 7'd64 : 7'd32;
      byte_last     = ~cur_byte[7];
      byte_overlong = cur_byte[7] && (idx_step == max_len);
      win_end       = (boff == {MEM_EXTRA{1'b1}});

      // Sign-extend only when the sign bit lands inside the target width.
      // shift_step stays below 64 whenever that test passes.
      value_final = acc_step;
      if (signed_q && cur_byte[6] && (shift_step < width_bits)) begin
         value_final = acc_step | (~64'd0 << shift_step);
      end
      if (!w64_q) begin
         value_final[63:32] = 32'd0;
      end

      value_overlong = acc_step;
      if (!w64_q) begin
         value_overlong[63:32] = 32'd0;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            state_next = mem_error ? S_IDLE : S_DECODE;
         end
         S_DECODE: begin
            if (byte_last || byte_overlong) begin
               state_next = S_IDLE;
            end else if (win_end) begin
               state_next = S_FETCH;
            end else begin
               state_next = S_DECODE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   always_comb begin
      busy      = (state != S_IDLE);
      mem_extra = {MEM_EXTRA{1'b1}};
   end

   // ------------------------------------------------------------------
   // Datapath and registered results
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= '0;
         signed_q <= 1'b0;
         w64_q    <= 1'b0;
         acc      <= 64'd0;
         idx      <= 4'd0;
         shift    <= 7'd0;
         buffer   <= '0;
         boff     <= '0;
         mem_addr <= '0;
         done     <= 1'b0;
         value    <= 64'd0;
         length   <= 4'd0;
         error    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  pc_q     <= pc;
                  signed_q <= is_signed;
                  w64_q    <= width64;
                  mem_addr <= pc;
                  acc      <= 64'd0;
                  idx      <= 4'd0;
                  shift    <= 7'd0;
                  value    <= 64'd0;
                  length   <= 4'd0;
                  error    <= 1'b0;
               end
            end
            S_FETCH: begin
               if (mem_error) begin
                  done   <= 1'b1;
                  error  <= 1'b1;
                  length <= idx;
                  value  <= 64'd0;
               end else begin
                  buffer <= mem_data;
                  boff   <= '0;
               end
            end
            S_DECODE: begin
               acc   <= acc_step;
               shift <= shift_step;
               idx   <= idx_step;
               boff  <= boff + 1'b1;
               if (byte_last) begin
                  done   <= 1'b1;
                  error  <= 1'b0;
                  length <= idx_step;
                  value  <= value_final;
               end else if (byte_overlong) begin
                  done   <= 1'b1;
                  error  <= 1'b1;
                  length <= idx_step;
                  value  <= value_overlong;
               end else if (win_end) begin
                  // The next window starts at the first byte not yet
                  // consumed. The address wraps around the ROM.
                  mem_addr <= pc_q + AW'(idx_step);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_leb128_reader.sv
// tb/tb_leb128_reader.sv - self-checking bench for leb128_reader

module tb_leb128_reader;

   localparam int MEM_DEPTH = 5;
   localparam int MEM_EXTRA = 2;
   localparam int ROM_SIZE  = 64;
   localparam int WIN       = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  pc;
   logic        is_signed;
   logic        width64;
   logic        busy;
   logic        done;
   logic [63:0] value;
   logic [3:0]  length;
   logic        error;
   logic [5:0]  mem_addr;
   logic [1:0]  mem_extra;
   logic [31:0] mem_data;
   logic        mem_error;

   logic [7:0]  rom [0:ROM_SIZE-1];
   int          rom_upper_bound;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Combinational ROM window behind the registered mem_addr
   always_comb begin
      mem_data = 32'd0;
      for (int i = 0; i < WIN; i++) begin
         mem_data[i*8 +: 8] = rom[(int'(mem_addr) + i) % ROM_SIZE];
      end
      mem_error = (int'(mem_addr) > rom_upper_bound);
   end

   leb128_reader #(
      .MEM_DEPTH (MEM_DEPTH),
      .MEM_EXTRA (MEM_EXTRA)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .pc        (pc),
      .is_signed (is_signed),
      .width64   (width64),
      .busy      (busy),
      .done      (done),
      .value     (value),
      .length    (length),
      .error     (error),
      .mem_addr  (mem_addr),
      .mem_extra (mem_extra),
      .mem_data  (mem_data),
      .mem_error (mem_error)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: walks the encoding byte by byte with plain arithmetic.
   // Windows are WIN bytes long and start at pc + (multiple of WIN).
   function automatic void model(input int p, input bit sgn, input bit w64,
                                 output logic [63:0] v, output int len,
                                 output bit err, output int lat);
      int              maxlen;
      longint unsigned acc;
      int              n;
      logic [7:0]      b;
      maxlen = w64 ? 10 : 5;
      acc    = 0;
      n      = 0;
      err    = 1'b0;
      forever begin
         if ((n % WIN) == 0 && ((p + n) % ROM_SIZE) > rom_upper_bound) begin
            v   = 64'd0;
            len = n;
            err = 1'b1;
            lat = n + n / WIN + 1;
            return;
         end
         b   = rom[(p + n) % ROM_SIZE];
         acc = acc | (longint'(b[6:0]) << (7 * n));
         n++;
         if (!b[7]) begin
            if (sgn && b[6] && (7 * n) < (w64 ? 64 : 32)) begin
               acc = acc | (~64'd0 << (7 * n));
            end
            break;
         end
         if (n == maxlen) begin
            err = 1'b1;
            break;
         end
      end
      if (!w64) acc = acc & 64'h0000_0000_FFFF_FFFF;
      v   = acc;
      len = n;
      lat = n + 1 + (n - 1) / WIN;
   endfunction

   // Issues one decode and checks the result, latency and pulse shape.
   // With poke set, a conflicting start is raised while the block is busy.
   task automatic decode(input string tag, input logic [5:0] p, input bit sgn,
                         input bit w64, input bit poke, input logic [63:0] exp_v,
                         input int exp_len, input bit exp_err, input int exp_lat);
      int lat;
      start     = 1'b1;
      pc        = p;
      is_signed = sgn;
      width64   = w64;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy_after_start"}, busy, 1);
      lat = 0;
      while (lat < 40) begin
         if (poke && lat == 1) begin
            start     = 1'b1;
            pc        = p + 6'd17;
            is_signed = ~sgn;
            width64   = ~w64;
         end
         @(posedge clk); #1;
         start     = 1'b0;
         pc        = p;
         is_signed = sgn;
         width64   = w64;
         lat++;
         if (done) break;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_value"}, value, exp_v);
      check({tag, "_length"}, length, exp_len);
      check({tag, "_error"}, error, exp_err);
      check({tag, "_busy_in_done"}, busy, 0);
      @(posedge clk); #1;
      check({tag, "_single_done"}, done, 0);
      check({tag, "_value_hold"}, value, exp_v);
   endtask

   task automatic put(input int p, input logic [7:0] b);
      rom[p % ROM_SIZE] = b;
   endtask

   initial begin
      logic [63:0] mv;
      int          ml;
      bit          me;
      int          mlat;
      bit          done_seen;
      int          p;
      bit          sgn;
      bit          w64;
      int          maxlen;
      int          enc_len;
      logic [7:0]  b;

      for (int i = 0; i < ROM_SIZE; i++) rom[i] = 8'($urandom);
      rom_upper_bound = ROM_SIZE - 1;
      reset     = 1'b0;
      start     = 1'b0;
      pc        = 6'd0;
      is_signed = 1'b0;
      width64   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_value", value, 0);
      check("rst_length", length, 0);
      check("rst_error", error, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_extra", mem_extra, 2'b11);
      reset = 1'b1;
      @(posedge clk); #1;

      // Single byte
      put(0, 8'h02);
      decode("t1", 6'd0, 0, 0, 0, 64'd2, 1, 0, 2);

      // Three bytes inside one window
      put(4, 8'hE5); put(5, 8'h8E); put(6, 8'h26);
      decode("t2", 6'd4, 0, 0, 0, 64'h98765, 3, 0, 4);

      // Signed cases
      put(10, 8'h7F);
      decode("t3a", 6'd10, 1, 0, 0, 64'h0000_0000_FFFF_FFFF, 1, 0, 2);
      put(20, 8'hC0); put(21, 8'hBB); put(22, 8'h78);
      decode("t3b", 6'd20, 1, 1, 0, 64'hFFFF_FFFF_FFFE_1DC0, 3, 0, 4);

      // Crosses a window boundary once
      put(2, 8'h80); put(3, 8'h80); put(4, 8'h80); put(5, 8'h80); put(6, 8'h01);
      decode("t4", 6'd2, 0, 0, 0, 64'h1000_0000, 5, 0, 7);

      // Overlong for 32-bit; terminated at byte 10 for 64-bit
      for (int i = 30; i < 36; i++) put(i, 8'h80);
      put(36, 8'h80); put(37, 8'h80); put(38, 8'h80); put(39, 8'h01);
      decode("t5a", 6'd30, 0, 0, 0, 64'd0, 5, 1, 7);
      decode("t5b", 6'd30, 0, 1, 0, 64'h8000_0000_0000_0000, 10, 0, 13);
      put(39, 8'h80);
      decode("t5c", 6'd30, 0, 1, 0, 64'd0, 10, 1, 13);

      // Start while busy is ignored
      decode("t6_poke", 6'd2, 0, 0, 1, 64'h1000_0000, 5, 0, 7);

      // ROM bound below pc, then bound hit on a refetch
      rom_upper_bound = 9;
      decode("t6_bound", 6'd12, 0, 0, 0, 64'd0, 0, 1, 1);
      rom_upper_bound = 43;
      put(40, 8'h81); put(41, 8'h82); put(42, 8'h83); put(43, 8'h84);
      put(44, 8'h85); put(45, 8'h06);
      decode("t6_bound2", 6'd40, 0, 1, 0, 64'd0, 4, 1, 6);
      rom_upper_bound = ROM_SIZE - 1;

      // Reset in the middle of a decode
      start     = 1'b1;
      pc        = 6'd30;
      is_signed = 1'b0;
      width64   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("midrst_done", done, 0);
      check("midrst_busy", busy, 0);
      check("midrst_value", value, 0);
      check("midrst_length", length, 0);
      check("midrst_error", error, 0);
      check("midrst_mem_addr", mem_addr, 0);
      repeat (2) @(posedge clk);
      #1;
      reset     = 1'b1;
      done_seen = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done) done_seen = 1'b1;
      end
      check("midrst_no_done", done_seen, 0);

      // Normal decode after the reset
      decode("t6_after_rst", 6'd0, 0, 0, 0, 64'd2, 1, 0, 2);

      // Randomised encodings against the reference
      for (int it = 0; it < 40; it++) begin
         p       = $urandom_range(0, ROM_SIZE - 1);
         sgn     = 1'($urandom);
         w64     = 1'($urandom);
         maxlen  = w64 ? 10 : 5;
         enc_len = $urandom_range(1, maxlen + 1);
         for (int k = 0; k < enc_len; k++) begin
            b = 8'($urandom);
            b[7] = (k < enc_len - 1) || (enc_len > maxlen);
            put(p + k, b);
         end
         rom_upper_bound = ($urandom_range(0, 5) == 0) ? $urandom_range(0, ROM_SIZE - 1)
                                                       : ROM_SIZE - 1;
         model(p, sgn, w64, mv, ml, me, mlat);
         decode($sformatf("rnd%0d", it), 6'(p), sgn, w64, 0, mv, ml, me, mlat);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
